// File: rtl/cordic_bus_regfile.sv
// cordic_bus_regfile
//
// Host-visible register file in front of the CORDIC Controller. Holds the
// control word and X/Y/Z operands the Controller consumes, takes the
// Controller's control/flag write-backs, captures the datapath results on a
// completing write-back, and turns the Controller interrupt level into a
// clear-on-read pending bit that drives the host irq line.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   hostAddr/hostWrEn/hostRdEn  host word address and one-cycle strobes
//   hostWrData/hostRdData       host write data / registered read data
//   hostRdValid                 one-cycle pulse, the cycle after hostRdEn
//   controlRegisterInput        CONTROL register, to the Controller
//   xInput/yInput/zInput        operand registers, to the Controller
//   controlRegisterOutput       Controller control/flag word
//   controlRegisterWriteEnable  Controller write-back strobe
//   xResult/yResult/zResult     Controller datapath values
//   interrupt                   Controller interrupt level
//   irq                         host interrupt (registered pending bit)
//
// Address map: 0 CONTROL, 1 X_IN, 2 Y_IN, 3 Z_IN, 4 X_RES, 5 Y_RES,
// 6 Z_RES, 7 STATUS {collision, busy, irqPending}. Other addresses read 0.
//
// Optional build macro CORDIC_BUS_CYCLE_COUNT_EN: adds a read-only,
// saturating 32-bit CYCLES counter at address 8, cleared by an accepted start
// and counting every clock spent BUSY. Without it address 8 reads 0.
//
// Host handshake: hostWrEn and hostRdEn are single-cycle strobes that are
// always accepted (there is no ready/back-pressure). A write takes effect at
// the clock edge that samples it. A read samples the register contents before
// that edge and presents them on hostRdData together with a one-cycle
// hostRdValid pulse. hostRdData then holds until the next read.

module cordic_bus_regfile #(
  parameter int          p_WIDTH      = 32,
  parameter int          p_ADDR_WIDTH = 4,
  parameter logic [31:0] p_CTRL_RESET = 32'h00011FF0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [p_ADDR_WIDTH-1:0] hostAddr,
  input  logic                    hostWrEn,
  input  logic                    hostRdEn,
  input  logic [p_WIDTH-1:0]      hostWrData,
  output logic [p_WIDTH-1:0]      hostRdData,
  output logic                    hostRdValid,
  output logic [31:0]             controlRegisterInput,
  output logic [p_WIDTH-1:0]      xInput,
  output logic [p_WIDTH-1:0]      yInput,
  output logic [p_WIDTH-1:0]      zInput,
  input  logic [31:0]             controlRegisterOutput,
  input  logic                    controlRegisterWriteEnable,
  input  logic [p_WIDTH-1:0]      xResult,
  input  logic [p_WIDTH-1:0]      yResult,
  input  logic [p_WIDTH-1:0]      zResult,
  input  logic                    interrupt,
  output logic                    irq
);

  localparam logic [p_ADDR_WIDTH-1:0] A_CONTROL = p_ADDR_WIDTH'(0);
  localparam logic [p_ADDR_WIDTH-1:0] A_X_IN    = p_ADDR_WIDTH'(1);
  localparam logic [p_ADDR_WIDTH-1:0] A_Y_IN    = p_ADDR_WIDTH'(2);
  localparam logic [p_ADDR_WIDTH-1:0] A_Z_IN    = p_ADDR_WIDTH'(3);
  localparam logic [p_ADDR_WIDTH-1:0] A_X_RES   = p_ADDR_WIDTH'(4);
  localparam logic [p_ADDR_WIDTH-1:0] A_Y_RES   = p_ADDR_WIDTH'(5);
  localparam logic [p_ADDR_WIDTH-1:0] A_Z_RES   = p_ADDR_WIDTH'(6);
  localparam logic [p_ADDR_WIDTH-1:0] A_STATUS  = p_ADDR_WIDTH'(7);
`ifdef CORDIC_BUS_CYCLE_COUNT_EN
  localparam logic [p_ADDR_WIDTH-1:0] A_CYCLES  = p_ADDR_WIDTH'(8);
`endif

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state;
  state_t stateNext;

  logic [31:0]        ctrlReg;
  logic [31:0]        ctrlNext;
  logic [p_WIDTH-1:0] xIn;
  logic [p_WIDTH-1:0] yIn;
  logic [p_WIDTH-1:0] zIn;
  logic [p_WIDTH-1:0] xRes;
  logic [p_WIDTH-1:0] yRes;
  logic [p_WIDTH-1:0] zRes;
  logic               irqPending;
  logic               collision;
  logic               collisionSet;
  logic               interruptPrev;
  logic [p_WIDTH-1:0] rdMux;
  logic [31:0]        hostWrWord;

`ifdef CORDIC_BUS_CYCLE_COUNT_EN
  logic [31:0]        cycleCount;
`endif

  logic busy;
  logic wbReady;
  logic wrControl;
  logic wrStatus;
  logic rdStatus;
  logic startAccept;
  logic interruptRise;
  logic irqClear;
  logic collisionClear;

  assign busy           = (state == BUSY);
  assign wbReady        = controlRegisterOutput[16];
  assign hostWrWord     = 32'(hostWrData);
  assign wrControl      = hostWrEn && (hostAddr == A_CONTROL);
  assign wrStatus       = hostWrEn && (hostAddr == A_STATUS);
  assign rdStatus       = hostRdEn && (hostAddr == A_STATUS);
  // A start that coincides with a write-back is dropped (collision).
  assign startAccept    = wrControl && !busy && !controlRegisterWriteEnable
                          && hostWrWord[0];
  assign interruptRise  = interrupt && !interruptPrev;
  assign irqClear       = rdStatus || (wrStatus && hostWrData[0]);
  assign collisionClear = wrStatus && hostWrData[2];

  assign controlRegisterInput = ctrlReg;
  assign xInput               = xIn;
  assign yInput               = yIn;
  assign zInput               = zIn;

  // FSM next state
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (startAccept) stateNext = BUSY;
      BUSY: if (controlRegisterWriteEnable && wbReady) stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // CONTROL next value. The Controller write-back always wins; while BUSY
  // the stop bit (bit1) stays sticky across intermediate write-backs and is
  // dropped by the completing one. A host stop request landing on the same
  // edge as a write-back is merged in; any other colliding host CONTROL
  // write is lost and flagged.
  always_comb begin
    ctrlNext     = ctrlReg;
    collisionSet = 1'b0;
    if (controlRegisterWriteEnable) begin
      ctrlNext = controlRegisterOutput;
      if (busy) begin
        ctrlNext[1] = wbReady ? 1'b0 : (controlRegisterOutput[1] | ctrlReg[1]);
      end
      if (wrControl) begin
        if (busy && hostWrWord[1]) ctrlNext[1] = 1'b1;
        else                       collisionSet = 1'b1;
      end
    end else if (wrControl) begin
      if (busy) ctrlNext[1] = ctrlReg[1] | hostWrWord[1];
      else      ctrlNext    = hostWrWord;
    end
  end

  // Register file state
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrlReg       <= p_CTRL_RESET;
      xIn           <= '0;
      yIn           <= '0;
      zIn           <= '0;
      xRes          <= '0;
      yRes          <= '0;
      zRes          <= '0;
      collision     <= 1'b0;
      irqPending    <= 1'b0;
      interruptPrev <= 1'b0;
      irq           <= 1'b0;
    end else begin
      ctrlReg <= ctrlNext;

      // Operands are frozen while the Controller is working on them.
      if (hostWrEn && !busy) begin
        if (hostAddr == A_X_IN) xIn <= hostWrData;
        if (hostAddr == A_Y_IN) yIn <= hostWrData;
        if (hostAddr == A_Z_IN) zIn <= hostWrData;
      end

      if (controlRegisterWriteEnable && wbReady) begin
        xRes <= xResult;
        yRes <= yResult;
        zRes <= zResult;
      end

      // Set has priority over clear for both sticky flags.
      collision     <= collisionSet || (collision && !collisionClear);
      irqPending    <= interruptRise || (irqPending && !irqClear);
      interruptPrev <= interrupt;
      irq           <= irqPending;
    end
  end

`ifdef CORDIC_BUS_CYCLE_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycleCount <= '0;
    end else if (startAccept) begin
      cycleCount <= '0;
    end else if (busy && (cycleCount != 32'hFFFF_FFFF)) begin
      cycleCount <= cycleCount + 32'd1;
    end
  end
`endif

  // Read mux sees pre-edge contents, so a STATUS read returns the value
  // before its own clear and a same-address write is not visible yet.
  always_comb begin
    rdMux = '0;
    case (hostAddr)
      A_CONTROL: rdMux = p_WIDTH'(ctrlReg);
      A_X_IN:    rdMux = xIn;
      A_Y_IN:    rdMux = yIn;
      A_Z_IN:    rdMux = zIn;
      A_X_RES:   rdMux = xRes;
      A_Y_RES:   rdMux = yRes;
      A_Z_RES:   rdMux = zRes;
      A_STATUS:  rdMux = p_WIDTH'({collision, busy, irqPending});
`ifdef CORDIC_BUS_CYCLE_COUNT_EN
      A_CYCLES:  rdMux = p_WIDTH'(cycleCount);
`endif
      default:   rdMux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hostRdData  <= '0;
      hostRdValid <= 1'b0;
    end else begin
      hostRdValid <= hostRdEn;
      if (hostRdEn) hostRdData <= rdMux;
    end
  end

endmodule

// File: tb/tb_cordic_bus_regfile.sv
// Testbench for cordic_bus_regfile: directed steps from the register map
// behaviour followed by randomized traffic, all compared each cycle against a
// behavioural model of the register file.

module tb_cordic_bus_regfile;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]   hostAddr;
  logic         hostWrEn;
  logic         hostRdEn;
  logic [W-1:0] hostWrData;
  logic [W-1:0] hostRdData;
  logic         hostRdValid;
  logic [31:0]  controlRegisterInput;
  logic [W-1:0] xInput;
  logic [W-1:0] yInput;
  logic [W-1:0] zInput;
  logic [31:0]  controlRegisterOutput;
  logic         controlRegisterWriteEnable;
  logic [W-1:0] xResult;
  logic [W-1:0] yResult;
  logic [W-1:0] zResult;
  logic         interrupt;
  logic         irq;

  cordic_bus_regfile dut (
    .clk                        (clk),
    .rst                        (rst),
    .hostAddr                   (hostAddr),
    .hostWrEn                   (hostWrEn),
    .hostRdEn                   (hostRdEn),
    .hostWrData                 (hostWrData),
    .hostRdData                 (hostRdData),
    .hostRdValid                (hostRdValid),
    .controlRegisterInput       (controlRegisterInput),
    .xInput                     (xInput),
    .yInput                     (yInput),
    .zInput                     (zInput),
    .controlRegisterOutput      (controlRegisterOutput),
    .controlRegisterWriteEnable (controlRegisterWriteEnable),
    .xResult                    (xResult),
    .yResult                    (yResult),
    .zResult                    (zResult),
    .interrupt                  (interrupt),
    .irq                        (irq)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  logic [31:0]  m_ctrl;
  logic [W-1:0] m_in  [0:2];
  logic [W-1:0] m_res [0:2];
  logic         m_busy, m_pend, m_coll, m_int_prev, m_irq, m_rd_valid;
  logic [W-1:0] m_rd_hold;
  logic [31:0]  m_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl     = 32'h00011FF0;
    for (int i = 0; i < 3; i++) begin
      m_in[i]  = '0;
      m_res[i] = '0;
    end
    m_busy     = 1'b0;
    m_pend     = 1'b0;
    m_coll     = 1'b0;
    m_int_prev = 1'b0;
    m_irq      = 1'b0;
    m_rd_valid = 1'b0;
    m_rd_hold  = '0;
    m_cyc      = '0;
    exp_q.delete();
  endtask

  function automatic logic [W-1:0] model_read(input logic [3:0] a);
    case (a)
      4'd0:             return m_ctrl;
      4'd1, 4'd2, 4'd3: return m_in[int'(a) - 1];
      4'd4, 4'd5, 4'd6: return m_res[int'(a) - 4];
      4'd7:             return {29'd0, m_coll, m_busy, m_pend};
`ifdef CORDIC_BUS_CYCLE_COUNT_EN
      4'd8:             return m_cyc;
`endif
      default:          return '0;
    endcase
  endfunction

  // Apply the register-file rules to the inputs that the next edge samples.
  task automatic model_step();
    logic [31:0] wd, co, n_ctrl;
    logic wr_c, wr_s, rise, start, n_busy, n_coll;
    if (rst) begin
      model_reset();
      return;
    end
    wd     = hostWrData;
    co     = controlRegisterOutput;
    wr_c   = hostWrEn && (hostAddr == 4'd0);
    wr_s   = hostWrEn && (hostAddr == 4'd7);
    rise   = interrupt && !m_int_prev;
    start  = 1'b0;
    n_ctrl = m_ctrl;
    n_busy = m_busy;
    n_coll = m_coll && !(wr_s && wd[2]);

    m_rd_valid = hostRdEn;
    if (hostRdEn) exp_q.push_back(model_read(hostAddr));

    if (controlRegisterWriteEnable) begin
      n_ctrl = co;
      if (m_busy && co[16]) n_ctrl[1] = 1'b0;
      else if (m_busy)      n_ctrl[1] = co[1] | m_ctrl[1];
      if (wr_c) begin
        if (m_busy && wd[1]) n_ctrl[1] = 1'b1;
        else                 n_coll = 1'b1;
      end
      if (co[16]) begin
        m_res[0] = xResult;
        m_res[1] = yResult;
        m_res[2] = zResult;
        n_busy   = 1'b0;
      end
    end else if (wr_c) begin
      if (m_busy) n_ctrl[1] = m_ctrl[1] | wd[1];
      else begin
        n_ctrl = wd;
        start  = wd[0];
        if (start) n_busy = 1'b1;
      end
    end

    if (!m_busy && hostWrEn && hostAddr >= 4'd1 && hostAddr <= 4'd3)
      m_in[int'(hostAddr) - 1] = wd;

    if (start) m_cyc = '0;
    else if (m_busy && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;

    m_irq      = m_pend;
    m_pend     = rise || (m_pend && !(hostRdEn && hostAddr == 4'd7) && !(wr_s && wd[0]));
    m_int_prev = interrupt;
    m_ctrl     = n_ctrl;
    m_busy     = n_busy;
    m_coll     = n_coll;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("ctrl_in", controlRegisterInput, m_ctrl);
    check("x_in", xInput, m_in[0]);
    check("y_in", yInput, m_in[1]);
    check("z_in", zInput, m_in[2]);
    check("irq", 32'(irq), 32'(m_irq));
    check("rd_valid", 32'(hostRdValid), 32'(m_rd_valid));
    if (m_rd_valid && exp_q.size() > 0) m_rd_hold = exp_q.pop_front();
    check("rd_data", hostRdData, m_rd_hold);
    hostWrEn                   = 1'b0;
    hostRdEn                   = 1'b0;
    controlRegisterWriteEnable = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    hostAddr   = a;
    hostWrData = d;
    hostWrEn   = 1'b1;
    tick();
  endtask

  task automatic wb(input logic [31:0] o, input logic [31:0] x, input logic [31:0] y,
                    input logic [31:0] z);
    controlRegisterOutput      = o;
    xResult                    = x;
    yResult                    = y;
    zResult                    = z;
    controlRegisterWriteEnable = 1'b1;
    tick();
  endtask

  task automatic rd_expect(input string tag, input logic [3:0] a, input logic [31:0] e);
    hostAddr = a;
    hostRdEn = 1'b1;
    tick();
    check(tag, hostRdData, e);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation time limit reached");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    hostAddr = '0; hostWrEn = 1'b0; hostRdEn = 1'b0; hostWrData = '0;
    controlRegisterOutput = '0; controlRegisterWriteEnable = 1'b0;
    xResult = '0; yResult = '0; zResult = '0; interrupt = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    check("reset_ctrl_in", controlRegisterInput, 32'h00011FF0);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_rd_valid", 32'(hostRdValid), 32'd0);
    rd_expect("reset_control", 4'd0, 32'h00011FF0);
    rd_expect("reset_status", 4'd7, 32'd0);

    // Basic operation
    wr(4'd1, 32'h26DD3B6A);
    wr(4'd2, 32'h0);
    wr(4'd3, 32'h20000000);
    wr(4'd0, 32'h00001F3D);
    rd_expect("status_busy", 4'd7, 32'h2);
    wb(32'h00001F3C, 32'h0, 32'h0, 32'h0);
    check("start_cleared", controlRegisterInput, 32'h00001F3C);
    rd_expect("status_still_busy", 4'd7, 32'h2);
    wb(32'h07C11F3C, 32'h5A82, 32'h5A82, 32'h0);
    rd_expect("status_done", 4'd7, 32'h0);
    rd_expect("x_res", 4'd4, 32'h5A82);
    rd_expect("y_res", 4'd5, 32'h5A82);
    rd_expect("z_res", 4'd6, 32'h0);
    rd_expect("control_after", 4'd0, 32'h07C11F3C);

    // Writes while BUSY: operands frozen, CONTROL only takes stop
    wr(4'd0, 32'h00001F3D);
    wr(4'd1, 32'h00001234);
    check("x_frozen", xInput, 32'h26DD3B6A);
    wr(4'd0, 32'hFFFF0002);
    check("stop_only", controlRegisterInput, 32'h00001F3F);
    wb(32'h00001F3C, 32'h0, 32'h0, 32'h0);
    check("stop_held", 32'(controlRegisterInput[1]), 32'd1);
    wb(32'h07C11F3C, 32'h1, 32'h2, 32'h3);
    check("stop_cleared", 32'(controlRegisterInput[1]), 32'd0);
    rd_expect("status_idle", 4'd7, 32'h0);

    // Interrupt pending / clear-on-read
    interrupt = 1'b1;
    tick();
    check("irq_one_edge", 32'(irq), 32'd0);
    tick();
    check("irq_two_edges", 32'(irq), 32'd1);
    rd_expect("status_irq", 4'd7, 32'h1);
    tick();
    check("irq_dropped", 32'(irq), 32'd0);
    interrupt = 1'b0;
    tick();
    interrupt = 1'b1;
    hostAddr  = 4'd7;
    hostRdEn  = 1'b1;
    tick();
    check("rise_with_read", hostRdData, 32'h0);
    tick();
    check("irq_set_wins", 32'(irq), 32'd1);
    wr(4'd7, 32'h1);
    interrupt = 1'b0;
    tick();
    check("irq_wr_clear", 32'(irq), 32'd0);
    rd_expect("status_clear", 4'd7, 32'h0);

    // Collision in IDLE
    hostAddr   = 4'd0;
    hostWrData = 32'h00001F3D;
    hostWrEn   = 1'b1;
    wb(32'h00011F00, 32'h0, 32'h0, 32'h0);
    rd_expect("collision_ctrl", 4'd0, 32'h00011F00);
    rd_expect("collision_flag", 4'd7, 32'h4);
    wr(4'd7, 32'h4);
    rd_expect("collision_cleared", 4'd7, 32'h0);

    // Same-address read and write returns the old value
    hostAddr   = 4'd1;
    hostWrData = 32'hAAAA5555;
    hostWrEn   = 1'b1;
    hostRdEn   = 1'b1;
    tick();
    check("rw_old", hostRdData, 32'h26DD3B6A);
    rd_expect("rw_new", 4'd1, 32'hAAAA5555);
    rd_expect("unmapped", 4'd12, 32'h0);

    // Reset in the middle of an operation
    wr(4'd0, 32'h00001F3D);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ctrl", controlRegisterInput, 32'h00011FF0);
    check("midrst_x", xInput, 32'h0);
    rd_expect("midrst_status", 4'd7, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      hostAddr                   = 4'($urandom_range(0, 9));
      hostWrEn                   = ($urandom_range(0, 3) == 0);
      hostRdEn                   = ($urandom_range(0, 2) == 0);
      hostWrData                 = $urandom;
      controlRegisterWriteEnable = ($urandom_range(0, 5) == 0);
      controlRegisterOutput      = $urandom & 32'hFFFF_FFFD;
      xResult                    = $urandom;
      yResult                    = $urandom;
      zResult                    = $urandom;
      if ($urandom_range(0, 7) == 0) interrupt = ~interrupt;
      tick();
    end
    interrupt = 1'b0;

    // Cycle counter
    wb(32'h00010000, 32'h0, 32'h0, 32'h0);
    wr(4'd0, 32'h00001F3D);
    for (int i = 0; i < 33; i++) tick();
    wb(32'h07C11F3C, 32'h0, 32'h0, 32'h0);
`ifdef CORDIC_BUS_CYCLE_COUNT_EN
    rd_expect("cycles_34", 4'd8, 32'd34);
    tick();
    rd_expect("cycles_hold", 4'd8, 32'd34);
    wr(4'd0, 32'h00001F3D);
    rd_expect("cycles_restart", 4'd8, 32'd0);
`else
    rd_expect("cycles_absent", 4'd8, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_bus_regfile.md
Name: cordic_bus_regfile

Overview:
Memory-mapped register file between the host bus and the CORDIC Controller. It holds the operand and control registers that feed the Controller's bus port, and writes back the Controller's control/flag word. It also captures results on completion and latches the Controller's interrupt into a clear-on-read pending bit.

Parameters:
p_WIDTH, 32, data/operand width
p_ADDR_WIDTH, 4, host word-address width
p_CTRL_RESET, 32'h00011FF0, control register reset value (ready=1, 31 iterations, all enables set)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
hostAddr  in  p_ADDR_WIDTH  word address
hostWrEn  in  1  write strobe, one cycle
hostRdEn  in  1  read strobe, one cycle
hostWrData  in  p_WIDTH  write data
hostRdData  out  p_WIDTH  read data
hostRdValid  out  1  read data valid pulse
controlRegisterInput  out  32  control word to Controller
xInput, yInput, zInput  out  p_WIDTH each  operands to Controller
controlRegisterOutput  in  32  Controller control/flag word
controlRegisterWriteEnable  in  1  Controller write-back strobe
xResult, yResult, zResult  in  p_WIDTH each  Controller datapath values
interrupt  in  1  Controller interrupt level
irq  out  1  host interrupt (pending bit)

Behaviour:
- Map: 0 CONTROL, 1 X_IN, 2 Y_IN, 3 Z_IN, 4 X_RES, 5 Y_RES, 6 Z_RES, 7 STATUS. All others read 0; writes to them are ignored.
- STATUS: bit0 irqPending, bit1 busy, bit2 collision. All other bits read 0.
- Reset: CONTROL=p_CTRL_RESET; operands, results and STATUS = 0; hostRdData=0; hostRdValid=0; irq=0; state IDLE.
- State machine IDLE/BUSY:
  - IDLE->BUSY when a host write to CONTROL sets bit0 (start).
  - BUSY->IDLE on a Controller write-back with controlRegisterOutput[16]=1 (ready).
  - busy = (state==BUSY).
- Start handling: start bit stays set in CONTROL until the first write-back with ready=0. That write-back copies controlRegisterOutput, so start reads back 0.
- Stop handling: while BUSY, a CONTROL write sets only bit1 (stop); all other bits of the write are ignored. Stop is cleared by the completion write-back.
- Operand writes (addr 1-3) while BUSY are ignored. In IDLE they take effect next cycle.
- Write-back: when controlRegisterWriteEnable=1, CONTROL <= controlRegisterOutput.
  - If ready=1, X/Y/Z_RES capture xResult/yResult/zResult in the same edge.
- Same-cycle host CONTROL write and write-back:
  - Write-back wins.
  - If BUSY and the host data has bit1 set, bit1 is ORed into the stored value.
  - Otherwise the host write is dropped and STATUS.collision is set.
  - collision is cleared by writing 1 to STATUS bit2.
- Interrupt: rising edge of interrupt (registered previous value) sets irqPending.
  - Cleared by a STATUS read or by writing 1 to STATUS bit0.
  - Set and clear in the same cycle: set wins.
  - irq = irqPending, registered.
- Reads: hostRdData/hostRdValid are registered one cycle after hostRdEn.
  - hostRdValid is a 1-cycle pulse; hostRdData holds its value until the next read.
  - A STATUS read returns the pre-clear value.
- Simultaneous hostRdEn and hostWrEn to the same address: the read returns the old value.
- rst mid-operation: everything returns to reset values in one edge; a pending start is discarded.

Optional Feature:
CORDIC_BUS_CYCLE_COUNT_EN
- Defined: address 8 is CYCLES, a 32-bit counter.
  - Cleared on the start write.
  - Increments every clk while BUSY; saturates at 32'hFFFFFFFF.
  - Read-only; holds its value after completion.
- Undefined: no counter logic; address 8 reads 0.

Test Plan:
- Reset then read CONTROL -> 32'h00011FF0; STATUS -> 0; irq=0.
- Write X_IN=32'h26DD3B6A, Y_IN=0, Z_IN=32'h20000000, then CONTROL=32'h00001F3D. Drive a write-back with output 32'h00001F3C, then 32'h07C11F3C with results 5A82,5A82,0 -> STATUS.busy 1 then 0; X_RES=32'h5A82; CONTROL reads 32'h07C11F3C.
- While BUSY, write X_IN=32'h1234 and CONTROL=32'h2 -> X_IN unchanged; controlRegisterInput[1]=1 until completion write-back.
- Interrupt rises on cycle N -> irq=1 at N+2; STATUS read returns bit0=1 and irq drops next cycle; a rise coinciding with the read leaves irq=1.
- IDLE host CONTROL write on the same cycle as a write-back -> write-back value stored, STATUS bit2=1; writing STATUS=4 clears it.
- (CORDIC_BUS_CYCLE_COUNT_EN) Start, hold BUSY 34 cycles -> CYCLES reads 34 after completion; a new start clears it to 0.
